// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_wr_arbiter                                               |
// | Purpose  : Packet-granular round-robin arbiter sharing the write port of |
// |            one asynchronous FIFO among N_REQ sources in the write-clock  |
// |            domain. A packet is only granted when the FIFO can hold all   |
// |            of it, so packets are never interleaved or stalled for space. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*LEN_W-1:0] i_len,
  input  logic [N_REQ*DW-1:0]    i_data,
  input  logic [N_REQ-1:0]       i_valid,
  output logic [N_REQ-1:0]       o_ready,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_busy,
  output logic [DW-1:0]          o_fifo_wr_data,
  output logic                   o_fifo_wr_en,
  input  logic                   i_fifo_full,
  input  logic [LEN_W-1:0]       i_fifo_wr_words,
  output logic                   o_err_len
);

  localparam int                 c_ptr_w   = $clog2(N_REQ);
  localparam logic [LEN_W:0]     c_depth   = (LEN_W+1)'(DEPTH);
  localparam logic [LEN_W-1:0]   c_len_one = LEN_W'(1);
  localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(N_REQ-1);
  localparam logic [N_REQ-1:0]   c_one_hot = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_REQ-1:0]     r_grant;
  logic [c_ptr_w-1:0]   r_ptr;
  logic [LEN_W-1:0]     r_cnt;
  logic                 r_err_len;

  logic [LEN_W-1:0]     w_len_arr  [N_REQ];
  logic [DW-1:0]        w_data_arr [N_REQ];

  logic                 w_found;
  logic [c_ptr_w-1:0]   w_cand;
  logic [c_ptr_w-1:0]   w_idx;
  logic [LEN_W-1:0]     w_raw_len;
  logic                 w_bad_len;
  logic [LEN_W-1:0]     w_eff_len;
  logic [LEN_W:0]       w_free;
  logic                 w_grant_ok;

  logic [c_ptr_w-1:0]   w_owner;
  logic [DW-1:0]        w_owner_data;
  logic                 w_owner_valid;
  logic                 w_accept;
  logic                 w_last;

  // Split the flat per-requester buses into indexable arrays.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_len_arr[gi]  = i_len[gi*LEN_W +: LEN_W];
      assign w_data_arr[gi] = i_data[gi*DW +: DW];
    end
  endgenerate

  // Round-robin candidate: first active request at or above the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = c_ptr_w'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_cand  = w_idx;
      end
    end
  end

  // Illegal lengths (0 or above DEPTH) are flagged and shrunk to a single word,
  // and the shrunk length is what must fit, so such packets still make progress.
  assign w_raw_len  = w_len_arr[w_cand];
  assign w_bad_len  = (w_raw_len == '0) || ({1'b0, w_raw_len} > c_depth);
  assign w_eff_len  = w_bad_len ? c_len_one : w_raw_len;
  assign w_free     = ({1'b0, i_fifo_wr_words} >= c_depth) ? '0
                                                           : (c_depth - {1'b0, i_fifo_wr_words});
  assign w_grant_ok = (r_state == ARB) && w_found && ({1'b0, w_eff_len} <= w_free);

  // Decode the registered one-hot grant into an owner index, data and valid.
  always_comb begin
    w_owner       = '0;
    w_owner_data  = '0;
    w_owner_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_grant[k]) begin
        w_owner       = c_ptr_w'(k);
        w_owner_data  = w_data_arr[k];
        w_owner_valid = i_valid[k];
      end
    end
  end

  // Full gating here is what keeps an externally shared FIFO from overflowing.
  assign w_accept = (r_state == XFER) && w_owner_valid && !i_fifo_full;
  assign w_last   = w_accept && (r_cnt == c_len_one);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ARB holds on the same candidate until its packet fits.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_state_nxt = ARB;
        end
      end
      ARB: begin
        if (!(|i_req)) begin
          w_state_nxt = IDLE;
        end else if (w_grant_ok) begin
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant register: set at arbitration, cleared with the packet's last word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant <= '0;
    end else if (w_grant_ok) begin
      r_grant <= c_one_hot << w_cand;
    end else if (w_last) begin
      r_grant <= '0;
    end
  end

  // Remaining-word counter: loaded at grant, stepped on each accepted word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_grant_ok) begin
      r_cnt <= w_eff_len;
    end else if (w_accept) begin
      r_cnt <= r_cnt - c_len_one;
    end
  end

  // Priority pointer moves past the owner only when its packet completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_last) begin
      r_ptr <= (w_owner == c_last) ? '0 : (w_owner + c_ptr_w'(1));
    end
  end

  // Sticky illegal-length flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_len <= 1'b0;
    end else if (w_grant_ok && w_bad_len) begin
      r_err_len <= 1'b1;
    end
  end

  assign o_grant        = r_grant;
  assign o_busy         = (r_state == XFER);
  assign o_ready        = r_grant & {N_REQ{w_accept}};
  assign o_fifo_wr_en   = w_accept;
  assign o_fifo_wr_data = (r_state == XFER) ? w_owner_data : '0;
  assign o_err_len      = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fifo_wr_arbiter                                            |
// | Purpose  : Self-checking bench for fifo_wr_arbiter with a transaction-   |
// |            level reference model, a FIFO environment and directed plus   |
// |            randomized stimulus.                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    i_req, i_valid, o_ready, o_grant;
  logic [N*LW-1:0] i_len;
  logic [N*DW-1:0] i_data;
  logic            o_busy, o_fifo_wr_en, i_fifo_full, o_err_len;
  logic [DW-1:0]   o_fifo_wr_data;
  logic [LW-1:0]   i_fifo_wr_words;

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_len(i_len), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .o_grant(o_grant), .o_busy(o_busy),
    .o_fifo_wr_data(o_fifo_wr_data), .o_fifo_wr_en(o_fifo_wr_en),
    .i_fifo_full(i_fifo_full), .i_fifo_wr_words(i_fifo_wr_words), .o_err_len(o_err_len)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_log[$];
  logic [N-1:0]  grant_log[$];
  logic          wr_seen = 1'b0;
  logic [DW-1:0] wr_val  = '0;
  logic [N-1:0]  last_grant = '0;
  bit            drain_en = 1'b0;
  int            drain_pct = 100;
  bit            ext_full = 1'b0;

  // reference model state: 0 idle, 1 waiting for a grant, 2 moving a packet
  bit m_live = 1'b0;
  int m_mode, m_owner, m_left, m_ptr;
  bit m_err;
  int cand, l, eff, free_sp;
  bit e_xfer, e_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo_flags();
    i_fifo_wr_words = LW'(fifo_q.size());
    i_fifo_full     = ext_full || (fifo_q.size() >= DEPTH);
  endtask

  // FIFO environment reacting to what the DUT wrote in the cycle just ended
  task automatic env_update();
    if (wr_seen) begin
      check("fifo_no_overflow", 64'(fifo_q.size() < DEPTH), 1);
      fifo_q.push_back(wr_val);
      wr_log.push_back(wr_val);
    end
    if (drain_en && fifo_q.size() > 0 && $urandom_range(99) < drain_pct)
      void'(fifo_q.pop_front());
    drive_fifo_flags();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    env_update();
    if (o_grant != '0 && last_grant == '0) grant_log.push_back(o_grant);
    last_grant = o_grant;
  endtask

  // data word carries its source number in the top nibble
  task automatic rand_data();
    for (int r = 0; r < N; r++) i_data[r*DW +: DW] = {4'(r), 12'($urandom)};
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; i_req = '0; i_valid = '0; ext_full = 1'b0;
    repeat (2) tick();
    fifo_q.delete(); wr_log.delete(); grant_log.delete();
    drive_fifo_flags();
    last_grant = '0;
    rst_n = 1'b1;
  endtask

  task automatic serve(input int maxc);
    int c = 0;
    while (o_busy && c < maxc) begin
      i_req   = i_req & ~o_grant;
      i_valid = o_grant;
      rand_data();
      tick();
      c++;
    end
    check("serve_done", 64'(o_busy), 0);
    i_valid = '0;
  endtask

  task automatic wait_grant(input int maxc);
    int c = 0;
    while (o_grant == '0 && c < maxc) begin
      tick();
      c++;
    end
    check("grant_timeout", 64'(o_grant != '0), 1);
  endtask

  // Reference model: check this cycle's outputs, then advance to the next cycle
  always @(negedge clk) begin
    wr_seen = o_fifo_wr_en;
    wr_val  = o_fifo_wr_data;
    e_xfer  = (m_mode == 2);
    e_acc   = e_xfer && i_valid[m_owner] && !i_fifo_full;
    if (m_live) begin
      check("grant",   64'(o_grant),        e_xfer ? 64'(1 << m_owner) : 0);
      check("busy",    64'(o_busy),         64'(e_xfer));
      check("ready",   64'(o_ready),        e_acc ? 64'(1 << m_owner) : 0);
      check("wr_en",   64'(o_fifo_wr_en),   64'(e_acc));
      check("wr_data", 64'(o_fifo_wr_data), e_xfer ? 64'(i_data[m_owner*DW +: DW]) : 0);
      check("err_len", 64'(o_err_len),      64'(m_err));
    end
    if (rst_n !== 1'b1) begin
      m_live = 1'b1; m_mode = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_err = 1'b0;
    end else if (m_live) begin
      case (m_mode)
        0: if (i_req != '0) m_mode = 1;
        1: begin
          if (i_req == '0) begin
            m_mode = 0;
          end else begin
            cand = -1;
            for (int k = 0; k < N; k++)
              if (cand < 0 && i_req[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
            l       = int'(i_len[cand*LW +: LW]);
            eff     = (l == 0 || l > DEPTH) ? 1 : l;
            free_sp = (int'(i_fifo_wr_words) >= DEPTH) ? 0 : DEPTH - int'(i_fifo_wr_words);
            if (free_sp >= eff) begin
              m_owner = cand;
              m_left  = eff;
              m_mode  = 2;
              if (l == 0 || l > DEPTH) m_err = 1'b1;
            end
          end
        end
        default: begin
          if (e_acc) begin
            m_left--;
            if (m_left == 0) begin
              m_mode = 0;
              m_ptr  = (m_owner + 1) % N;
            end
          end
        end
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_rr [5];
    logic [4:0]   pat;
    int n0;
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_n = 1'b0; i_req = '0; i_valid = '0; i_len = '0; i_data = '0;
    drive_fifo_flags();

    // reset held with all requests active, then first grant two cycles later
    i_req = '1;
    i_len = {4{4'd2}};
    repeat (3) tick();
    check("t1_rst_grant", 64'(o_grant), 0);
    check("t1_rst_wr_en", 64'(o_fifo_wr_en), 0);
    check("t1_rst_busy",  64'(o_busy), 0);
    rst_n = 1'b1;
    tick();
    check("t1_arb_grant", 64'(o_grant), 0);
    tick();
    check("t1_first_grant", 64'(o_grant), 4'b0001);

    // round robin with everyone requesting len 2 and a fast drain
    drain_en = 1'b1; drain_pct = 100;
    for (int c = 0; c < 80 && grant_log.size() < 5; c++) begin
      i_valid = o_grant;
      rand_data();
      tick();
    end
    for (int i = 0; i < 5; i++)
      check("t2_rr_order", 64'(grant_log.size() > i ? grant_log[i] : 4'h0), 64'(exp_rr[i]));
    for (int i = 0; i < 8; i++)
      check("t2_word_src", 64'(wr_log.size() > i ? wr_log[i][DW-1:DW-4] : 4'hf), 64'(i / 2));

    // space gating: 5 words held, len 4 must wait; req1 may not bypass
    reset_dut();
    drain_en = 1'b0;
    repeat (5) fifo_q.push_back(16'hdead);
    drive_fifo_flags();
    i_len = '0; i_len[3:0] = 4'd4; i_len[7:4] = 4'd1;
    i_req = 4'b0011;
    repeat (4) tick();
    check("t3_wait_grant", 64'(o_grant), 0);
    check("t3_wait_busy",  64'(o_busy), 0);
    void'(fifo_q.pop_front());
    drive_fifo_flags();
    tick();
    check("t3_grant0", 64'(o_grant), 4'b0001);
    n0 = wr_log.size();
    serve(40);
    check("t3_words", 64'(wr_log.size() - n0), 4);
    drain_en = 1'b1;
    wait_grant(60);
    check("t3_next_grant", 64'(o_grant), 4'b0010);
    serve(40);

    // valid gaps: len 3 with valid 1,0,1,0,1
    reset_dut();
    i_len = '0; i_len[3:0] = 4'd3;
    i_req = 4'b0001;
    wait_grant(10);
    i_req = '0;
    n0 = wr_log.size();
    pat = 5'b10101;
    for (int k = 0; k < 5; k++) begin
      i_valid[0] = pat[k];
      tick();
    end
    i_valid = '0;
    check("t4_words", 64'(wr_log.size() - n0), 3);
    check("t4_idle",  64'(o_busy), 0);

    // illegal lengths 0 and 9 behave as a single word and set the sticky flag
    reset_dut();
    i_len = '0;
    i_req = 4'b0100;
    wait_grant(10);
    check("t5_len0_err", 64'(o_err_len), 1);
    n0 = wr_log.size();
    serve(20);
    check("t5_len0_words", 64'(wr_log.size() - n0), 1);
    check("t5_sticky", 64'(o_err_len), 1);
    reset_dut();
    check("t5_err_cleared", 64'(o_err_len), 0);
    i_len[11:8] = 4'd9;
    i_req = 4'b0100;
    wait_grant(10);
    check("t5_len9_err", 64'(o_err_len), 1);
    n0 = wr_log.size();
    serve(20);
    check("t5_len9_words", 64'(wr_log.size() - n0), 1);

    // reset mid-packet; pointer sits at 3 beforehand so a 0001 grant proves reset
    reset_dut();
    i_len = '0; i_len[11:8] = 4'd1;
    i_req = 4'b0100;
    wait_grant(10);
    serve(20);
    i_len[7:4] = 4'd6;
    i_req = 4'b0010;
    wait_grant(10);
    check("t6_grant1", 64'(o_grant), 4'b0010);
    i_req = '0;
    n0 = wr_log.size();
    i_valid = 4'b0010;
    tick();
    tick();
    rst_n = 1'b0; i_valid = '0;
    tick();
    rst_n = 1'b1; i_valid = 4'b0010;
    repeat (3) tick();
    check("t6_words", 64'(wr_log.size() - n0), 2);
    i_valid = '0;
    i_len = {4{4'd1}};
    i_req = 4'b1111;
    wait_grant(10);
    check("t6_regrant0", 64'(o_grant), 4'b0001);

    // randomized traffic with space pressure, stalls and occasional resets
    reset_dut();
    drain_en = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 500 == 0) drain_pct = $urandom_range(90, 20);
      ext_full = ($urandom_range(99) < 8);
      drive_fifo_flags();
      for (int r = 0; r < N; r++) begin
        if (!i_req[r] && !o_grant[r] && $urandom_range(99) < 15) begin
          i_req[r] = 1'b1;
          if ($urandom_range(99) < 10)
            i_len[r*LW +: LW] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15, 9));
          else
            i_len[r*LW +: LW] = 4'($urandom_range(DEPTH, 1));
        end else if (i_req[r] && o_grant[r] && $urandom_range(99) < 50) begin
          i_req[r] = 1'b0;
        end
        if (o_grant[r]) begin
          i_valid[r] = ($urandom_range(99) < 70);
          if ($urandom_range(99) < 10) i_len[r*LW +: LW] = 4'($urandom);
        end else begin
          i_valid[r] = ($urandom_range(99) < 5);
        end
      end
      rand_data();
      rst_n = ($urandom_range(999) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write side of one 8x16 asynchronous FIFO among N_REQ packet sources, all in the FIFO write-clock domain.
- Round-robin arbitration at packet granularity.
- A packet is granted only when the FIFO has free space for the whole packet, so packets are never interleaved or stalled mid-transfer.
- Drives the FIFO write port: data, write enable. Consumes the FIFO full flag and write-side word count.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 16, data width in bits.
- DEPTH, 8, FIFO capacity in words.
- LEN_W, 4, width of the packet length field; must hold the value DEPTH.

Ports:
- clk  in  1  clock; same clock as the FIFO write clock.
- rst_n  in  1  synchronous reset, active low.
- i_req  in  N_REQ  per-requester packet request; held high until the packet's first word is accepted.
- i_len  in  N_REQ*LEN_W  per-requester packet length in words, legal range 1..DEPTH; sampled at grant.
- i_data  in  N_REQ*DW  per-requester write data.
- i_valid  in  N_REQ  per-requester data valid.
- o_ready  out  N_REQ  per-requester word accepted, asserted the same cycle as acceptance.
- o_grant  out  N_REQ  one-hot owner of the current packet.
- o_busy  out  1  high while in XFER.
- o_fifo_wr_data  out  DW  to the FIFO write data input.
- o_fifo_wr_en  out  1  to the FIFO write enable.
- i_fifo_full  in  1  from the FIFO full flag.
- i_fifo_wr_words  in  LEN_W  from the FIFO write-side occupancy (0..DEPTH).
- o_err_len  out  1  sticky flag; set when an illegal length is granted.

Behaviour:
- Reset (rst_n low at a posedge) values:
  - state = IDLE.
  - o_grant = 0, o_busy = 0, o_ready = 0, o_fifo_wr_en = 0, o_err_len = 0.
  - Round-robin pointer = 0.
  - Word counter = 0.
- Reset has priority over everything. Reset mid-packet abandons the packet with no further writes; words already written stay in the FIFO.
- States:
  - IDLE → ARB when any i_req is high.
  - ARB:
    - Candidate = first requester with i_req high, scanning from the pointer upward with wrap-around.
    - Free space = DEPTH − i_fifo_wr_words.
    - If free space ≥ the candidate's i_len: register o_grant = onehot(candidate), load the counter with i_len, go to XFER.
    - Otherwise stay in ARB and re-evaluate every cycle. Lower-priority requesters are not considered, so no bypass and no starvation.
    - If i_req drops to all zeros, return to IDLE.
  - XFER:
    - Acceptance = i_valid[g] & ~i_fifo_full.
    - o_fifo_wr_en, o_ready[g] and the acceptance condition are combinational and equal.
    - o_fifo_wr_data = i_data[g] (mux on the registered grant; zero when not in XFER).
    - Each accepted word decrements the counter.
    - On the word that takes the counter 1 → 0: next state IDLE, o_grant cleared, pointer = (g+1) mod N_REQ.
- Latency:
  - Request seen in IDLE → ARB next cycle → earliest grant registered at the end of the ARB cycle → first write in the following cycle.
  - Minimum 2 idle cycles between packets, so peak throughput is len/(len+2).
- Length handling:
  - Length 0 or > DEPTH at grant: o_err_len set (sticky until reset) and the length is treated as 1.
- i_len changes after grant are ignored.
- Requester behaviour:
  - i_req dropped by the owner during XFER is ignored; the packet runs to its length.
  - A requester must keep i_valid low when not granted; non-owner i_valid is ignored.
- Boundary conditions:
  - i_fifo_full during XFER (possible only if an external writer shares the FIFO): stall, no write, counter held.
  - Write count saturation: the FIFO never overflows because o_fifo_wr_en is gated by ~i_fifo_full.
  - Single requester: re-granted every packet.
  - i_fifo_wr_words = DEPTH in ARB: wait.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with i_req=4'b1111 → o_grant=0, o_fifo_wr_en=0, o_busy=0; release → grant 0001 after 2 cycles.
2. Round robin: all 4 requesters continuously request len=2, FIFO drained fast → grant sequence 0001, 0010, 0100, 1000, 0001; FIFO receives 2 words from each, in order, never interleaved.
3. Space gating: FIFO holds 5 words (wr_words=5), req0 len=4 → stays in ARB; drain to wr_words=4 → granted; exactly 4 writes; req1 len=1, pending during the wait, is not granted first.
4. Valid gaps: owner with len=3 toggles i_valid 1,0,1,0,1 → writes only on the 3 valid cycles; state returns to IDLE after the 3rd.
5. Illegal length: req2 len=0 → o_err_len=1, one word written, arbiter recovers; len=9 behaves the same.
6. Reset mid-packet: after 2 of 6 words, pulse rst_n low → no further o_fifo_wr_en; next grant goes to requester 0.
